mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 143 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Purpose: round-robin arbiter sharing one single-port memory between a fetch port and a data port.
// Latency: grant in the request cycle, mem_req one cycle later, response no earlier than two cycles after grant.
// Backpressure: a requester that loses arbitration or arrives while busy holds req until it sees its grant pulse.
module mem_port_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [3:0]  dm_wstrb,
  output logic        dm_gnt,
  output logic        dm_rvalid,
  output logic [31:0] dm_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        err
);

  // Counter only has to reach TIMEOUT-1, so log2(TIMEOUT) bits suffice.
  localparam int            CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic          owner_dm;   // 1 = data port owns the outstanding transaction
  logic          last_dm;    // 1 = data port received the most recent grant
  logic          cmd_we;
  logic [31:0]   cmd_addr;
  logic [31:0]   cmd_wdata;
  logic [3:0]    cmd_wstrb;

  logic          pick_dm;
  logic          pick_if;
  logic          in_idle;
  logic          in_wait;
  logic          timeout_hit;
  logic          resp;
  logic [31:0]   resp_data;

  // Round-robin pick: on a tie the port not granted last wins; reset leaves last_dm=0 so dm wins first.
  always_comb begin
    pick_dm = 1'b0;
    pick_if = 1'b0;
    if (dm_req && if_req) begin
      pick_dm = ~last_dm;
      pick_if = last_dm;
    end else begin
      pick_dm = dm_req;
      pick_if = if_req;
    end
  end

  // Every output is forced quiet while reset is high, including a response that would land in that cycle.
  assign in_idle     = (state == IDLE) && !reset;
  assign in_wait     = (state == WAIT) && !reset;
  assign timeout_hit = in_wait && !mem_rvalid && (wait_cnt == CNT_LAST);
  assign resp        = in_wait && (mem_rvalid || timeout_hit);
  assign resp_data   = mem_rvalid ? mem_rdata : 32'h0;

  assign if_gnt    = in_idle && pick_if;
  assign dm_gnt    = in_idle && pick_dm;
  assign if_rvalid = resp && !owner_dm;
  assign dm_rvalid = resp && owner_dm;
  assign if_rdata  = if_rvalid ? resp_data : 32'h0;
  assign dm_rdata  = dm_rvalid ? resp_data : 32'h0;
  assign err       = timeout_hit;

  assign mem_req   = (state == ISSUE) && !reset;
  assign busy      = (state != IDLE) && !reset;
  assign mem_we    = reset ? 1'b0  : cmd_we;
  assign mem_addr  = reset ? 32'h0 : cmd_addr;
  assign mem_wdata = reset ? 32'h0 : cmd_wdata;
  assign mem_wstrb = reset ? 4'h0  : cmd_wstrb;

  // Transaction FSM: latch the winner's command, issue it once, then wait for a response or time out.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      owner_dm  <= 1'b0;
      last_dm   <= 1'b0;
      cmd_we    <= 1'b0;
      cmd_addr  <= 32'h0;
      cmd_wdata <= 32'h0;
      cmd_wstrb <= 4'h0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_dm) begin
            owner_dm  <= 1'b1;
            last_dm   <= 1'b1;
            cmd_we    <= dm_we;
            cmd_addr  <= dm_addr;
            cmd_wdata <= dm_wdata;
            cmd_wstrb <= dm_wstrb;
            state     <= ISSUE;
          end else if (pick_if) begin
            owner_dm  <= 1'b0;
            last_dm   <= 1'b0;
            cmd_we    <= 1'b0;
            cmd_addr  <= if_addr;
            cmd_wdata <= 32'h0;
            cmd_wstrb <= 4'h0;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (mem_rvalid || timeout_hit) begin
            state <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose: randomized scoreboard bench for mem_port_arbiter against a transaction-level model.
// Latency: model predicts grant cycle, mem_req cycle and response cycle of every transaction.
// Backpressure: requesters hold req until granted and occasionally withdraw before a grant.
module tb_mem_port_arbiter;

  localparam int TO   = 4;
  localparam int NCYC = 3000;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_wstrb;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        err;

  always #5 clk = ~clk;

  mem_port_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_wstrb(dm_wstrb),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .busy(busy), .err(err)
  );

  typedef struct {
    bit          to_dm;
    logic [31:0] data;
    bit          err;
    int          cyc;
  } resp_t;

  resp_t sb[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc      = 0;

  // Model state, owned by the monitor
  bit          m_active    = 1'b0;
  bit          m_owner_dm  = 1'b0;
  bit          m_last_dm   = 1'b0;
  int          m_issue_cyc = -10;
  bit          m_gnt_if    = 1'b0;
  bit          m_gnt_dm    = 1'b0;
  logic        m_we        = 1'b0;
  logic [31:0] m_addr      = 32'h0;
  logic [31:0] m_wdata     = 32'h0;
  logic [3:0]  m_wstrb     = 4'h0;
  resp_t       e;

  // Stimulus state, owned by the driver
  bit          if_pend       = 1'b0;
  bit          dm_pend       = 1'b0;
  int          rsp_cyc       = -1;
  logic [31:0] rsp_data      = 32'h0;
  int          handled_issue = -10;
  bit          hang_next     = 1'b0;
  int          hang_issue    = -10;
  int          rst_cyc       = -10;
  int          lat;
  logic [31:0] d;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %08h expected %08h", name, cyc, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic new_if_cmd();
    if_pend = 1'b1;
    if_addr = $urandom & 32'hFFFF_FFFC;
  endtask

  task automatic new_dm_cmd();
    dm_pend  = 1'b1;
    dm_we    = 1'($urandom_range(0, 1));
    dm_addr  = $urandom;
    dm_wdata = $urandom;
    dm_wstrb = 4'($urandom_range(1, 15));
  endtask

  // Monitor: predicts arbitration, checks command/busy every cycle, pops the scoreboard on responses
  initial begin : monitor
    forever begin
      @(negedge clk);
      m_gnt_if = 1'b0;
      m_gnt_dm = 1'b0;
      if (reset) begin
        check1("rst_if_gnt", if_gnt, 1'b0);
        check1("rst_dm_gnt", dm_gnt, 1'b0);
        check1("rst_if_rvalid", if_rvalid, 1'b0);
        check1("rst_dm_rvalid", dm_rvalid, 1'b0);
        check1("rst_mem_req", mem_req, 1'b0);
        check1("rst_busy", busy, 1'b0);
        check1("rst_err", err, 1'b0);
        check1("rst_mem_we", mem_we, 1'b0);
        check32("rst_mem_addr", mem_addr, 32'h0);
        check32("rst_mem_wdata", mem_wdata, 32'h0);
        check32("rst_mem_wstrb", {28'h0, mem_wstrb}, 32'h0);
        check32("rst_if_rdata", if_rdata, 32'h0);
        check32("rst_dm_rdata", dm_rdata, 32'h0);
        sb.delete();
        m_active    = 1'b0;
        m_last_dm   = 1'b0;
        m_issue_cyc = -10;
      end else begin
        if (!m_active && (if_req || dm_req)) begin
          if (if_req && dm_req) m_gnt_dm = !m_last_dm;
          else                  m_gnt_dm = dm_req;
          m_gnt_if    = !m_gnt_dm;
          m_active    = 1'b1;
          m_owner_dm  = m_gnt_dm;
          m_last_dm   = m_gnt_dm;
          m_issue_cyc = cyc + 1;
          if (m_gnt_dm) begin
            m_we = dm_we; m_addr = dm_addr; m_wdata = dm_wdata; m_wstrb = dm_wstrb;
          end else begin
            m_we = 1'b0; m_addr = if_addr; m_wdata = 32'h0; m_wstrb = 4'h0;
          end
        end
        check1("if_gnt", if_gnt, m_gnt_if);
        check1("dm_gnt", dm_gnt, m_gnt_dm);
        check1("busy", busy, m_active && (cyc >= m_issue_cyc));
        check1("mem_req", mem_req, m_active && (cyc == m_issue_cyc));
        if (m_active && cyc >= m_issue_cyc) begin
          check32("mem_addr", mem_addr, m_addr);
          check1("mem_we", mem_we, m_we);
          check32("mem_wstrb", {28'h0, mem_wstrb}, {28'h0, m_wstrb});
          if (m_we) check32("mem_wdata", mem_wdata, m_wdata);
        end
        if (if_rvalid || dm_rvalid || (sb.size() > 0 && sb[0].cyc == cyc)) begin
          if (sb.size() == 0) begin
            check32("spurious_rvalid", {30'h0, if_rvalid, dm_rvalid}, 32'h0);
          end else begin
            e = sb.pop_front();
            check32("resp_cycle", cyc, e.cyc);
            check1("if_rvalid", if_rvalid, !e.to_dm);
            check1("dm_rvalid", dm_rvalid, e.to_dm);
            if (e.to_dm) check32("dm_rdata", dm_rdata, e.data);
            else         check32("if_rdata", if_rdata, e.data);
            check1("err", err, e.err);
            m_active = 1'b0;
          end
        end else begin
          check1("err_quiet", err, 1'b0);
        end
      end
    end
  end

  // Driver: requesters, memory responder with random latency, stray responses and mid-WAIT resets
  initial begin : driver
    reset      = 1'b1;
    if_req     = 1'b0;
    if_addr    = 32'h0;
    dm_req     = 1'b0;
    dm_we      = 1'b0;
    dm_addr    = 32'h0;
    dm_wdata   = 32'h0;
    dm_wstrb   = 4'h0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    for (int k = 0; k < NCYC + 30; k++) begin
      @(posedge clk);
      cyc++;
      #1;
      if (m_gnt_if) if_pend = 1'b0;
      if (m_gnt_dm) dm_pend = 1'b0;

      reset = (cyc <= 3);
      if (cyc == 1000 || cyc == 2000) hang_next = 1'b1;
      if (hang_issue >= 0 && cyc == hang_issue + 2) begin
        reset      = 1'b1;
        rst_cyc    = cyc;
        hang_issue = -10;
        rsp_cyc    = -1;
        if (!if_pend) new_if_cmd();
        if (!dm_pend) new_dm_cmd();
      end

      if (k < NCYC) begin
        if (!if_pend) begin
          if ($urandom_range(0, 2) == 0) new_if_cmd();
        end else if (cyc != rst_cyc + 1 && $urandom_range(0, 15) == 0) begin
          if_pend = 1'b0;
        end
        if (!dm_pend) begin
          if ($urandom_range(0, 2) == 0) new_dm_cmd();
        end else if (cyc != rst_cyc + 1 && $urandom_range(0, 15) == 0) begin
          dm_pend = 1'b0;
        end
      end
      if_req = if_pend;
      dm_req = dm_pend;

      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
      if (!reset && m_active && cyc == m_issue_cyc && handled_issue != cyc) begin
        handled_issue = cyc;
        if (hang_next) begin
          lat        = TO + 10;
          hang_next  = 1'b0;
          hang_issue = cyc;
        end else begin
          lat = $urandom_range(1, TO + 2);
        end
        d = $urandom;
        if (lat <= TO) begin
          sb.push_back('{to_dm: m_owner_dm, data: d, err: 1'b0, cyc: cyc + lat});
          rsp_cyc  = cyc + lat;
          rsp_data = d;
        end else begin
          sb.push_back('{to_dm: m_owner_dm, data: 32'h0, err: 1'b1, cyc: cyc + TO});
          rsp_cyc = -1;
        end
      end
      if (cyc == rsp_cyc) begin
        mem_rvalid = 1'b1;
        mem_rdata  = rsp_data;
      end else if (cyc == rst_cyc + 1) begin
        mem_rvalid = 1'b1;
      end else if (!(m_active && cyc > m_issue_cyc) && $urandom_range(0, 3) == 0) begin
        mem_rvalid = 1'b1;
      end
    end
    @(negedge clk);
    #1;
    check32("scoreboard_drained", sb.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
